// File: rtl/crossbar_pkg.sv
// Shared constants, FSM state type and config-size helpers for param_crossbar.
package crossbar_pkg;
  localparam int CFG_W = 32;

  typedef enum logic {LOAD = 1'b0, PASS = 1'b1} cfg_state_t;

  function automatic int cfg_bits(input int w_ns, input int w_sn, input int w_we, input int w_ew);
    return w_sn + w_ew + w_ns + w_we + w_sn*w_we + w_ns*w_we + w_sn*w_ew + w_ns*w_ew;
  endfunction

  function automatic int cfg_words(input int w_ns, input int w_sn, input int w_we, input int w_ew);
    return cfg_bits(w_ns, w_sn, w_we, w_ew) / CFG_W;
  endfunction
endpackage

// File: rtl/Xnodes.sv
// Full crossbar region: sel[i*W_OUT+j] connects src[i] to dst[j], enabled paths OR together.
module Xnodes #(
  parameter int W_IN  = 1,
  parameter int W_OUT = 1
) (
  input  logic [W_IN-1:0]       src,
  input  logic [W_IN*W_OUT-1:0] sel,
  output logic [W_OUT-1:0]      dst
);
  for (genvar j = 0; j < W_OUT; j++) begin : g_col
    logic [W_IN-1:0] hit;
    for (genvar i = 0; i < W_IN; i++) begin : g_row
      assign hit[i] = src[i] & sel[i*W_OUT + j];
    end
    assign dst[j] = |hit;
  end
endmodule

// File: rtl/Ynodes.sv
// Straight-through track gates: dst[k] passes src[k] when sel[k] is set.
module Ynodes #(
  parameter int W = 1
) (
  input  logic [W-1:0] src,
  input  logic [W-1:0] sel,
  output logic [W-1:0] dst
);
  assign dst = src & sel;
endmodule

// File: rtl/crossbar_cfg_ctrl.sv
// Config loader: shadow shift chain with checksum, daisy-chain pass-through and commit to active.
module crossbar_cfg_ctrl
  import crossbar_pkg::*;
#(
  parameter int L = 75
) (
  input  logic               clk,
  input  logic               res,
  input  logic [CFG_W-1:0]   cfg_data_i,
  input  logic               cfg_valid_i,
  output logic               cfg_ready_o,
  output logic [CFG_W-1:0]   cfg_data_o,
  output logic               cfg_valid_o,
  input  logic               cfg_ready_i,
  input  logic               cfg_commit_i,
  output logic               cfg_done_o,
  output logic               cfg_err_o,
  output logic [L*CFG_W-1:0] active
);
  localparam int CW = $clog2(L + 1);

  cfg_state_t               state;
  logic [L-1:0][CFG_W-1:0]  shadow;
  logic [CW-1:0]            cnt;
  logic [CFG_W-1:0]         csum;
  logic                     ok;

  // Once loaded, this stage is transparent so the next instance can fill.
  assign cfg_ready_o = (state == PASS) ? cfg_ready_i : 1'b1;
  assign cfg_valid_o = (state == PASS) ? cfg_valid_i : 1'b0;
  assign cfg_data_o  = (state == PASS) ? cfg_data_i  : '0;

  always_ff @(posedge clk) begin
    if (res) begin
      state      <= LOAD;
      shadow     <= '0;
      active     <= '0;
      cnt        <= '0;
      csum       <= '0;
      ok         <= 1'b0;
      cfg_done_o <= 1'b0;
      cfg_err_o  <= 1'b0;
    end else begin
      cfg_done_o <= 1'b0;
      case (state)
        LOAD: begin
          if (cfg_commit_i) cfg_err_o <= 1'b1;
          if (cfg_valid_i) begin
            // The word after the L-th is the checksum and is not stored.
            if (cnt == CW'(L)) begin
              ok    <= (cfg_data_i == csum);
              state <= PASS;
            end else begin
              shadow <= {shadow[L-2:0], cfg_data_i};
              cnt    <= cnt + 1'b1;
              csum   <= csum ^ cfg_data_i;
            end
          end
        end
        PASS: begin
          if (cfg_commit_i) begin
            if (ok) begin
              active     <= shadow;
              cfg_done_o <= 1'b1;
              cfg_err_o  <= 1'b0;
            end else begin
              cfg_err_o  <= 1'b1;
            end
            state <= LOAD;
            cnt   <= '0;
            csum  <= '0;
            ok    <= 1'b0;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: rtl/param_crossbar.sv
// Four-quadrant configurable track crossbar with daisy-chained, checksummed configuration.
module param_crossbar
  import crossbar_pkg::*;
#(
  parameter int W_NS    = 32,
  parameter int W_SN    = 16,
  parameter int W_WE    = 32,
  parameter int W_EW    = 16,
  parameter int OUT_REG = 0
) (
  input  logic             clk,
  input  logic             res,
  input  logic [CFG_W-1:0] cfg_data_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  output logic [CFG_W-1:0] cfg_data_o,
  output logic             cfg_valid_o,
  input  logic             cfg_ready_i,
  input  logic             cfg_commit_i,
  output logic             cfg_done_o,
  output logic             cfg_err_o,
  input  logic [W_NS-1:0]  N_i,
  output logic [W_NS-1:0]  S_o,
  input  logic [W_SN-1:0]  S_i,
  output logic [W_SN-1:0]  N_o,
  input  logic [W_WE-1:0]  W_i,
  output logic [W_WE-1:0]  E_o,
  input  logic [W_EW-1:0]  E_i,
  output logic [W_EW-1:0]  W_o
);
  localparam int L = cfg_words(W_NS, W_SN, W_WE, W_EW);

  if (cfg_bits(W_NS, W_SN, W_WE, W_EW) % CFG_W != 0) begin : g_bad_width
    $error("param_crossbar: total config bits must be a multiple of 32");
  end

  // Region offsets in the flat active vector, lowest bit first.
  localparam int O_YN = 0;
  localparam int O_YW = O_YN + W_SN;
  localparam int O_YS = O_YW + W_EW;
  localparam int O_YE = O_YS + W_NS;
  localparam int O_NW = O_YE + W_WE;
  localparam int O_NE = O_NW + W_SN*W_WE;
  localparam int O_SW = O_NE + W_NS*W_WE;
  localparam int O_SE = O_SW + W_SN*W_EW;

  logic [L*CFG_W-1:0] active;

  crossbar_cfg_ctrl #(.L(L)) u_ctrl (
    .clk, .res, .cfg_data_i, .cfg_valid_i, .cfg_ready_o, .cfg_data_o, .cfg_valid_o,
    .cfg_ready_i, .cfg_commit_i, .cfg_done_o, .cfg_err_o, .active
  );

  logic [W_SN-1:0] yn, nw;
  logic [W_EW-1:0] yw, sw;
  logic [W_NS-1:0] ys, se;
  logic [W_WE-1:0] ye, ne;

  Ynodes #(.W(W_SN)) y_n (.src(S_i), .sel(active[O_YN +: W_SN]), .dst(yn));
  Ynodes #(.W(W_EW)) y_w (.src(E_i), .sel(active[O_YW +: W_EW]), .dst(yw));
  Ynodes #(.W(W_NS)) y_s (.src(N_i), .sel(active[O_YS +: W_NS]), .dst(ys));
  Ynodes #(.W(W_WE)) y_e (.src(W_i), .sel(active[O_YE +: W_WE]), .dst(ye));

  // Turning paths: W->N, N->E, S->W, E->S.
  Xnodes #(.W_IN(W_WE), .W_OUT(W_SN)) x_nw (.src(W_i), .sel(active[O_NW +: W_SN*W_WE]), .dst(nw));
  Xnodes #(.W_IN(W_NS), .W_OUT(W_WE)) x_ne (.src(N_i), .sel(active[O_NE +: W_NS*W_WE]), .dst(ne));
  Xnodes #(.W_IN(W_SN), .W_OUT(W_EW)) x_sw (.src(S_i), .sel(active[O_SW +: W_SN*W_EW]), .dst(sw));
  Xnodes #(.W_IN(W_EW), .W_OUT(W_NS)) x_se (.src(E_i), .sel(active[O_SE +: W_NS*W_EW]), .dst(se));

  if (OUT_REG != 0) begin : g_reg
    always_ff @(posedge clk) begin
      if (res) begin
        N_o <= '0;
        E_o <= '0;
        S_o <= '0;
        W_o <= '0;
      end else begin
        N_o <= yn | nw;
        E_o <= ye | ne;
        S_o <= ys | se;
        W_o <= yw | sw;
      end
    end
  end else begin : g_comb
    always_comb begin
      N_o = yn | nw;
      E_o = ye | ne;
      S_o = ys | se;
      W_o = yw | sw;
    end
  end
endmodule

// File: tb/tb_param_crossbar.sv
// Directed/random bench: standalone instance (OUT_REG=0) plus a two-deep chain (OUT_REG=1 -> 0).
module tb_param_crossbar;
  localparam int L  = 75;
  localparam int NB = L * 32;
  localparam int O_YN = 0, O_YW = 16, O_YS = 32, O_YE = 64, O_NW = 96;
  localparam int O_NE = O_NW + 16*32, O_SW = O_NE + 32*32, O_SE = O_SW + 16*16;

  logic clk = 1'b0;
  logic res;
  always #5 clk = ~clk;

  logic [31:0] n_in, w_in;
  logic [15:0] s_in, e_in;

  logic [31:0] d0_data, d0_data_o;
  logic        d0_valid, d0_ready_o, d0_valid_o, d0_down_rdy, d0_commit, d0_done_o, d0_err_o;
  logic [15:0] d0_n, d0_w;
  logic [31:0] d0_s, d0_e;

  logic [31:0] c_data, ab_data, ub_data_o;
  logic        c_valid, ua_ready_o, ab_valid, ub_ready_o, ub_valid_o, sink_rdy, c_commit;
  logic        ua_done_o, ua_err_o, ub_done_o, ub_err_o;
  logic [15:0] ua_n, ua_w, ub_n, ub_w;
  logic [31:0] ua_s, ua_e, ub_s, ub_e;

  param_crossbar #(.OUT_REG(0)) d0 (
    .clk(clk), .res(res), .cfg_data_i(d0_data), .cfg_valid_i(d0_valid), .cfg_ready_o(d0_ready_o),
    .cfg_data_o(d0_data_o), .cfg_valid_o(d0_valid_o), .cfg_ready_i(d0_down_rdy),
    .cfg_commit_i(d0_commit), .cfg_done_o(d0_done_o), .cfg_err_o(d0_err_o),
    .N_i(n_in), .S_o(d0_s), .S_i(s_in), .N_o(d0_n), .W_i(w_in), .E_o(d0_e), .E_i(e_in), .W_o(d0_w));

  param_crossbar #(.OUT_REG(1)) ua (
    .clk(clk), .res(res), .cfg_data_i(c_data), .cfg_valid_i(c_valid), .cfg_ready_o(ua_ready_o),
    .cfg_data_o(ab_data), .cfg_valid_o(ab_valid), .cfg_ready_i(ub_ready_o),
    .cfg_commit_i(c_commit), .cfg_done_o(ua_done_o), .cfg_err_o(ua_err_o),
    .N_i(n_in), .S_o(ua_s), .S_i(s_in), .N_o(ua_n), .W_i(w_in), .E_o(ua_e), .E_i(e_in), .W_o(ua_w));

  param_crossbar #(.OUT_REG(0)) ub (
    .clk(clk), .res(res), .cfg_data_i(ab_data), .cfg_valid_i(ab_valid), .cfg_ready_o(ub_ready_o),
    .cfg_data_o(ub_data_o), .cfg_valid_o(ub_valid_o), .cfg_ready_i(sink_rdy),
    .cfg_commit_i(c_commit), .cfg_done_o(ub_done_o), .cfg_err_o(ub_err_o),
    .N_i(n_in), .S_o(ub_s), .S_i(s_in), .N_o(ub_n), .W_i(w_in), .E_o(ub_e), .E_i(e_in), .W_o(ub_w));

  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [31:0] sink_q[$];

  always @(posedge clk)
    if (!res && ub_valid_o && sink_rdy) sink_q.push_back(ub_data_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference routing: each output track is the OR of every enabled path feeding it.
  function automatic logic [31:0] model(input logic [NB-1:0] c, input int port);
    logic [31:0] r;
    r = '0;
    case (port)
      0: for (int k = 0; k < 16; k++) begin
           r[k] = c[O_YN+k] & s_in[k];
           for (int i = 0; i < 32; i++) r[k] = r[k] | (c[O_NW + i*16 + k] & w_in[i]);
         end
      1: for (int j = 0; j < 32; j++) begin
           r[j] = c[O_YE+j] & w_in[j];
           for (int i = 0; i < 32; i++) r[j] = r[j] | (c[O_NE + i*32 + j] & n_in[i]);
         end
      2: for (int j = 0; j < 32; j++) begin
           r[j] = c[O_YS+j] & n_in[j];
           for (int i = 0; i < 16; i++) r[j] = r[j] | (c[O_SE + i*32 + j] & e_in[i]);
         end
      default: for (int k = 0; k < 16; k++) begin
           r[k] = c[O_YW+k] & e_in[k];
           for (int i = 0; i < 16; i++) r[k] = r[k] | (c[O_SW + i*16 + k] & s_in[i]);
         end
    endcase
    return r;
  endfunction

  function automatic logic [31:0] obs(input int which, input int port);
    logic [31:0] v;
    case (which)
      0: v = (port == 0) ? {16'h0, d0_n} : (port == 1) ? d0_e : (port == 2) ? d0_s : {16'h0, d0_w};
      1: v = (port == 0) ? {16'h0, ua_n} : (port == 1) ? ua_e : (port == 2) ? ua_s : {16'h0, ua_w};
      default: v = (port == 0) ? {16'h0, ub_n} : (port == 1) ? ub_e : (port == 2) ? ub_s : {16'h0, ub_w};
    endcase
    return v;
  endfunction

  task automatic check_routes(input string tag, input int which, input logic [NB-1:0] c);
    for (int p = 0; p < 4; p++) chk($sformatf("%s_p%0d", tag, p), obs(which, p), model(c, p));
  endtask

  task automatic rand_inputs();
    n_in = $urandom; w_in = $urandom; s_in = 16'($urandom); e_in = 16'($urandom);
  endtask

  function automatic logic [NB-1:0] rand_cfg();
    logic [NB-1:0] c;
    for (int b = 0; b < NB; b++) c[b] = ($urandom_range(0, 31) == 0);
    return c;
  endfunction

  task automatic drive(input int which, input logic v, input logic [31:0] d);
    if (which == 0) begin d0_valid = v; d0_data = d; end
    else begin c_valid = v; c_data = d; end
  endtask

  // One word with random idle gaps; returns right after the transferring edge.
  task automatic send_word(input int which, input logic [31:0] w);
    bit sent, gap, rdy;
    sent = 0;
    for (int t = 0; t < 64 && !sent; t++) begin
      @(negedge clk);
      sink_rdy = 1'($urandom_range(0, 1));
      gap = ($urandom_range(0, 3) == 0);
      drive(which, !gap, w);
      #1;
      rdy = (which == 0) ? d0_ready_o : ua_ready_o;
      if (!gap && rdy) begin
        @(posedge clk);
        sent = 1;
      end
    end
    if (!sent) chk("send_timeout", 32'(sent), 32'd1);
  endtask

  task automatic load_cfg(input int which, input logic [NB-1:0] c, input bit bad);
    logic [31:0] x, w;
    x = '0;
    for (int k = 0; k < L; k++) begin
      w = c[32*(L-1-k) +: 32];
      x = x ^ w;
      send_word(which, w);
    end
    send_word(which, bad ? ~x : x);
    @(negedge clk);
    drive(which, 1'b0, 32'h0);
  endtask

  task automatic commit(input int which);
    @(negedge clk);
    if (which == 0) d0_commit = 1'b1; else c_commit = 1'b1;
    @(negedge clk);
    d0_commit = 1'b0;
    c_commit  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [NB-1:0] cfg_zero, cfg_d, cfg_r, cfg_r2, cfg_a, cfg_b;
  logic [31:0]   ex[6];

  initial begin
    cfg_zero = '0;
    res = 1'b1; d0_data = '0; d0_valid = 0; d0_down_rdy = 1; d0_commit = 0;
    c_data = '0; c_valid = 0; c_commit = 0; sink_rdy = 0;
    rand_inputs();
    n_in = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    check_routes("rst_d0", 0, cfg_zero);
    check_routes("rst_ua", 1, cfg_zero);
    chk("rst_ready", 32'(d0_ready_o), 32'd1);
    chk("rst_err", 32'(d0_err_o), 32'd0);
    chk("rst_done", 32'(d0_done_o), 32'd0);

    // NE diagonal: N_i[i] -> E_o[i].
    for (int i = 0; i < 32; i++) cfg_d[O_NE + i*32 + i] = 1'b1;
    for (int b = 0; b < NB; b++) if (b < O_NE || b >= O_NE + 1024 || ((b - O_NE) % 33) != 0) cfg_d[b] = 1'b0;
    load_cfg(0, cfg_d, 0);
    d0_down_rdy = 0; d0_valid = 1; d0_data = 32'h1234_5678;
    #1;
    chk("pass_rdy0", 32'(d0_ready_o), 32'd0);
    chk("pass_vld", 32'(d0_valid_o), 32'd1);
    chk("pass_data", d0_data_o, 32'h1234_5678);
    d0_down_rdy = 1;
    #1;
    chk("pass_rdy1", 32'(d0_ready_o), 32'd1);
    d0_valid = 0;
    rand_inputs();
    n_in = 32'hA5A5_0001;
    #1;
    check_routes("hold_before_commit", 0, cfg_zero);
    commit(0);
    chk("done_pulse", 32'(d0_done_o), 32'd1);
    chk("ne_diag_E", d0_e, 32'hA5A5_0001);
    check_routes("diag", 0, cfg_d);
    @(negedge clk);
    chk("done_low", 32'(d0_done_o), 32'd0);

    // Bad checksum: active untouched, sticky error, back in LOAD.
    cfg_r = rand_cfg();
    load_cfg(0, cfg_r, 1);
    commit(0);
    chk("bad_err", 32'(d0_err_o), 32'd1);
    chk("bad_done", 32'(d0_done_o), 32'd0);
    check_routes("bad_hold", 0, cfg_d);
    d0_down_rdy = 0;
    #1;
    chk("bad_state_load", 32'(d0_ready_o), 32'd1);
    d0_down_rdy = 1;

    // Good load clears error; random routing checks.
    load_cfg(0, cfg_r, 0);
    commit(0);
    chk("good_done", 32'(d0_done_o), 32'd1);
    chk("good_err_clr", 32'(d0_err_o), 32'd0);
    repeat (3) begin
      rand_inputs();
      #1;
      check_routes("rand", 0, cfg_r);
    end
    commit(0);
    chk("load_commit_err", 32'(d0_err_o), 32'd1);
    chk("load_commit_nodone", 32'(d0_done_o), 32'd0);
    check_routes("load_commit_hold", 0, cfg_r);

    // Reset in the middle of a load.
    for (int k = 0; k < 40; k++) send_word(0, $urandom);
    @(negedge clk);
    d0_valid = 0;
    res = 1'b1;
    @(negedge clk);
    res = 1'b0;
    chk("mid_rst_cnt", 32'(d0.u_ctrl.cnt), 32'd0);
    chk("mid_rst_err", 32'(d0_err_o), 32'd0);
    check_routes("mid_rst_out", 0, cfg_zero);
    cfg_r2 = rand_cfg();
    load_cfg(0, cfg_r2, 0);
    commit(0);
    chk("reload_done", 32'(d0_done_o), 32'd1);
    check_routes("reload", 0, cfg_r2);

    // Two-deep chain: 152 words, then pass-through with toggling downstream ready.
    cfg_a = rand_cfg();
    cfg_b = rand_cfg();
    load_cfg(1, cfg_a, 0);
    load_cfg(1, cfg_b, 0);
    rand_inputs();
    @(negedge clk);
    check_routes("chain_hold_a", 1, cfg_zero);
    check_routes("chain_hold_b", 2, cfg_zero);
    for (int k = 0; k < 5; k++) begin
      ex[k] = $urandom;
      send_word(1, ex[k]);
    end
    ex[5] = $urandom;
    @(negedge clk);
    c_valid = 1; c_data = ex[5]; sink_rdy = 1; c_commit = 1;
    @(negedge clk);
    c_valid = 0; c_commit = 0; sink_rdy = 0;
    chk("chain_done_a", 32'(ua_done_o), 32'd1);
    chk("chain_done_b", 32'(ub_done_o), 32'd1);
    chk("sink_count", 32'(sink_q.size()), 32'd6);
    for (int k = 0; k < 6; k++)
      chk($sformatf("sink_word%0d", k), (k < sink_q.size()) ? sink_q[k] : 32'hDEAD_BEEF, ex[k]);
    #1;
    chk("up_back_load_rdy", 32'(ua_ready_o), 32'd1);
    c_valid = 1;
    #1;
    chk("up_back_load_vld", 32'(ab_valid), 32'd0);
    c_valid = 0;
    check_routes("chain_b", 2, cfg_b);
    check_routes("chain_a_lat", 1, cfg_zero);
    @(negedge clk);
    check_routes("chain_a", 1, cfg_a);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
